// File: rtl/priors_load_sequencer.sv
// Sequences seed load, per-row prior load and a timed inference window for one left-priors decoder.
// Latency: decoder pins are registered, one cycle behind the state that drives them; done follows the last inference cycle.
// Backpressure: prior_ready_o is high for the whole LOAD state; optional stochastic counters under PRIORS_SEQ_STOCH_COUNT_EN.
module priors_load_sequencer #(
    parameter  int Narray     = 2,
    parameter  int Nword_used = 3,
    parameter  int Ncnt       = 16,
    localparam int R          = 2**Narray,
    localparam int W          = 2**Nword_used
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              clear_i,
    input  logic              mode_log_i,
    input  logic [W-1:0]      seed_in_i,
    input  logic [Ncnt-1:0]   n_infer_i,
    input  logic [W-1:0]      prior_in_i,
    input  logic              prior_valid_i,
    output logic              prior_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              activ_priors_o,
    output logic              load_priors_o,
    output logic              load_seed_o,
    output logic [Narray-1:0] adr_full_row_o,
    output logic [W-1:0]      priors_o,
    output logic [W-1:0]      seed_o,
    output logic              stoch_log_o,
`ifdef PRIORS_SEQ_STOCH_COUNT_EN
    input  logic [R-1:0]      priors_stoch_in_i,
    output logic [R*Ncnt-1:0] stoch_count_o,
`endif
    output logic              inference_o
);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_LOAD, S_INFER, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [Narray-1:0] row_q, row_d;
    logic [Ncnt-1:0]   cnt_q, cnt_d;
    logic [Ncnt-1:0]   n_infer_q, n_infer_d;
    logic              stoch_log_q, stoch_log_d;
    logic [W-1:0]      seed_q, seed_d;
    logic [W-1:0]      priors_q, priors_d;
    logic [Narray-1:0] adr_q, adr_d;
    logic              activ_q, activ_d;
    logic              load_priors_q, load_priors_d;
    logic              load_seed_q, load_seed_d;
    logic              inference_q, inference_d;
    logic              done_q, done_d;
    logic              hs;
    logic              last_row;

    assign prior_ready_o = (state_q == S_LOAD);
    assign hs            = prior_ready_o && prior_valid_i;
    assign last_row      = (row_q == Narray'(R-1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            cnt_q         <= '0;
            n_infer_q     <= '0;
            stoch_log_q   <= 1'b0;
            seed_q        <= '0;
            priors_q      <= '0;
            adr_q         <= '0;
            activ_q       <= 1'b0;
            load_priors_q <= 1'b0;
            load_seed_q   <= 1'b0;
            inference_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            n_infer_q     <= n_infer_d;
            stoch_log_q   <= stoch_log_d;
            seed_q        <= seed_d;
            priors_q      <= priors_d;
            adr_q         <= adr_d;
            activ_q       <= activ_d;
            load_priors_q <= load_priors_d;
            load_seed_q   <= load_seed_d;
            inference_q   <= inference_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = S_SEED;
                S_SEED:  state_d = S_LOAD;
                S_LOAD:  if (hs && last_row) state_d = (n_infer_q == '0) ? S_DONE : S_INFER;
                S_INFER: if (cnt_q <= Ncnt'(1)) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobes default low; data and config registers hold unless the state updates them.
    always_comb begin
        row_d         = row_q;
        cnt_d         = cnt_q;
        n_infer_d     = n_infer_q;
        stoch_log_d   = stoch_log_q;
        seed_d        = seed_q;
        priors_d      = priors_q;
        adr_d         = adr_q;
        activ_d       = activ_q;
        load_priors_d = 1'b0;
        load_seed_d   = 1'b0;
        inference_d   = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    stoch_log_d = mode_log_i;
                    seed_d      = seed_in_i;
                    n_infer_d   = n_infer_i;
                end
                if (clear_i) activ_d = 1'b0;
            end
            S_SEED: begin
                activ_d     = 1'b1;
                load_seed_d = 1'b1;
                row_d       = '0;
            end
            S_LOAD: begin
                if (hs) begin
                    load_priors_d = 1'b1;
                    adr_d         = row_q;
                    priors_d      = prior_in_i;
                    row_d         = row_q + Narray'(1);
                    if (last_row) cnt_d = n_infer_q;
                end
            end
            S_INFER: begin
                inference_d = 1'b1;
                cnt_d       = cnt_q - Ncnt'(1);
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
        if (abort_i) begin
            activ_d       = 1'b0;
            load_priors_d = 1'b0;
            load_seed_d   = 1'b0;
            inference_d   = 1'b0;
            done_d        = 1'b0;
            row_d         = '0;
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign activ_priors_o = activ_q;
    assign load_priors_o  = load_priors_q;
    assign load_seed_o    = load_seed_q;
    assign adr_full_row_o = adr_q;
    assign priors_o       = priors_q;
    assign seed_o         = seed_q;
    assign stoch_log_o    = stoch_log_q;
    assign inference_o    = inference_q;

`ifdef PRIORS_SEQ_STOCH_COUNT_EN
    logic [R*Ncnt-1:0] stoch_q, stoch_d;

    // Counts only cycles where the decoder actually sees inference on the stochastic path.
    always_comb begin
        stoch_d = stoch_q;
        if (state_q == S_IDLE && start_i && !abort_i) begin
            stoch_d = '0;
        end else if (inference_q && !stoch_log_q) begin
            for (int i = 0; i < R; i++) begin
                if (priors_stoch_in_i[i] && stoch_q[i*Ncnt +: Ncnt] != {Ncnt{1'b1}})
                    stoch_d[i*Ncnt +: Ncnt] = stoch_q[i*Ncnt +: Ncnt] + Ncnt'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stoch_q <= '0;
        else       stoch_q <= stoch_d;
    end

    assign stoch_count_o = stoch_q;
`endif

endmodule

// File: tb/tb_priors_load_sequencer.sv
// Directed bench for priors_load_sequencer: cycle table for one full run plus hand sequences for gaps, abort, reset and n_infer = 0.
module tb_priors_load_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, clear, mode_log, pv;
    logic [7:0]  seed_in, pin;
    logic [15:0] n_infer;
    logic        rdy, busy, done, act, lp, ls, sl, inf;
    logic [1:0]  adr;
    logic [7:0]  pri, seed;
`ifdef PRIORS_SEQ_STOCH_COUNT_EN
    logic [3:0]  pst;
    logic [63:0] scnt;
`endif

    always #5 clk = ~clk;

    priors_load_sequencer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .clear_i(clear),
        .mode_log_i(mode_log), .seed_in_i(seed_in), .n_infer_i(n_infer),
        .prior_in_i(pin), .prior_valid_i(pv), .prior_ready_o(rdy), .busy_o(busy),
        .done_o(done), .activ_priors_o(act), .load_priors_o(lp), .load_seed_o(ls),
        .adr_full_row_o(adr), .priors_o(pri), .seed_o(seed), .stoch_log_o(sl),
`ifdef PRIORS_SEQ_STOCH_COUNT_EN
        .priors_stoch_in_i(pst), .stoch_count_o(scnt),
`endif
        .inference_o(inf)
    );

    logic [25:0] obs;
    assign obs = {busy, rdy, done, act, lp, ls, adr, pri, inf, sl, seed};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // {start,abort,clear,valid}, prior_in, expected observation vector
    typedef struct packed {
        logic [3:0]  in;
        logic [7:0]  pin;
        logic [25:0] exp;
    } vec_t;

    function automatic vec_t v(input logic [3:0] i, input logic [7:0] p, input logic [5:0] flags,
                               input logic [1:0] a, input logic [7:0] pr, input logic [1:0] is,
                               input logic [7:0] sd);
        v = {i, p, flags, a, pr, is, sd};
    endfunction

    logic [7:0] pdat [4];
    int  lp_cnt, inf_cnt, done_cnt, bad_lp, rdy_break, sent, done_cyc, last_lp_cyc, abort_cyc;
    logic prev_hs, rdy_seen, aborted;

    // One run from IDLE: valid every `gap` cycles, abort on handshake index abort_idx (-1 = none).
    task automatic run(input int gap, input logic [15:0] n, input logic mode, input int abort_idx);
        seed_in = 8'h5A; mode_log = mode; n_infer = n;
        lp_cnt = 0; inf_cnt = 0; done_cnt = 0; bad_lp = 0; rdy_break = 0; sent = 0;
        done_cyc = -100; last_lp_cyc = -100; abort_cyc = -100;
        prev_hs = 1'b0; rdy_seen = 1'b0; aborted = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (lp !== prev_hs) bad_lp++;
            if (lp) begin
                chk("load_adr", {62'd0, adr}, lp_cnt);
                chk("load_dat", {56'd0, pri}, {56'd0, pdat[lp_cnt % 4]});
                lp_cnt++;
                last_lp_cyc = c;
            end
            if (ls) chk("seed_cfg", {55'd0, sl, seed}, {55'd0, mode, seed_in});
            if (inf) inf_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (rdy) rdy_seen = 1'b1;
            else if (rdy_seen && sent < 4 && !aborted) rdy_break++;
            if (c == abort_cyc + 1) chk("abort_next", {59'd0, busy, act, lp, ls, inf}, 64'd0);
            if (done_cnt > 0 && c > done_cyc + 2) break;
            if (aborted && c > abort_cyc + 6) break;
            pv = (sent < 4) && !aborted && (c % gap == 0);
            pin = pdat[sent % 4];
            abort = 1'b0;
            if (pv && sent == abort_idx) begin
                abort = 1'b1; aborted = 1'b1; abort_cyc = c;
            end
            prev_hs = pv && rdy && !abort;
            if (prev_hs) sent++;
            step();
        end
        pv = 1'b0; abort = 1'b0;
    endtask

    vec_t tbl [13];

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; clear = 1'b0; mode_log = 1'b0; pv = 1'b0;
        seed_in = 8'h00; pin = 8'h00; n_infer = 16'd0;
        pdat[0] = 8'h10; pdat[1] = 8'h40; pdat[2] = 8'h80; pdat[3] = 8'hFF;
`ifdef PRIORS_SEQ_STOCH_COUNT_EN
        pst = 4'b0101;
`endif
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_idle", {38'd0, obs}, 64'd0);
        end

        // Full run, back-to-back priors; start in LOAD is ignored; clear after done drops activ.
        tbl[0]  = v(4'b1000, 8'h00, 6'b000000, 2'd0, 8'h00, 2'b00, 8'h00);
        tbl[1]  = v(4'b0000, 8'h00, 6'b100000, 2'd0, 8'h00, 2'b00, 8'hA5);
        tbl[2]  = v(4'b0001, 8'h10, 6'b110101, 2'd0, 8'h00, 2'b00, 8'hA5);
        tbl[3]  = v(4'b1001, 8'h40, 6'b110110, 2'd0, 8'h10, 2'b00, 8'hA5);
        tbl[4]  = v(4'b0001, 8'h80, 6'b110110, 2'd1, 8'h40, 2'b00, 8'hA5);
        tbl[5]  = v(4'b0001, 8'hFF, 6'b110110, 2'd2, 8'h80, 2'b00, 8'hA5);
        tbl[6]  = v(4'b0000, 8'h00, 6'b100110, 2'd3, 8'hFF, 2'b00, 8'hA5);
        tbl[7]  = v(4'b0000, 8'h00, 6'b100100, 2'd3, 8'hFF, 2'b10, 8'hA5);
        tbl[8]  = v(4'b0000, 8'h00, 6'b100100, 2'd3, 8'hFF, 2'b10, 8'hA5);
        tbl[9]  = v(4'b0000, 8'h00, 6'b100100, 2'd3, 8'hFF, 2'b10, 8'hA5);
        tbl[10] = v(4'b0000, 8'h00, 6'b001100, 2'd3, 8'hFF, 2'b00, 8'hA5);
        tbl[11] = v(4'b0010, 8'h00, 6'b000100, 2'd3, 8'hFF, 2'b00, 8'hA5);
        tbl[12] = v(4'b0000, 8'h00, 6'b000000, 2'd3, 8'hFF, 2'b00, 8'hA5);
        seed_in = 8'hA5; mode_log = 1'b0; n_infer = 16'd3;
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("table_c%0d", i), {38'd0, obs}, {38'd0, tbl[i].exp});
            {start, abort, clear, pv} = tbl[i].in;
            pin = tbl[i].pin;
            step();
        end
        {start, abort, clear, pv} = 4'b0000;

        pdat[0] = 8'h11; pdat[1] = 8'h22; pdat[2] = 8'h33; pdat[3] = 8'h44;
        run(3, 16'd3, 1'b0, -1);
        chk("gap_pulses", lp_cnt, 4);
        chk("gap_no_stray", bad_lp, 0);
        chk("gap_rdy_held", rdy_break, 0);
        chk("gap_infer", inf_cnt, 3);
        chk("gap_done", done_cnt, 1);
        chk("gap_done_lat", done_cyc - last_lp_cyc, 4);
        chk("gap_activ", {63'd0, act}, 64'd1);

        run(1, 16'd0, 1'b0, -1);
        chk("n0_pulses", lp_cnt, 4);
        chk("n0_infer", inf_cnt, 0);
        chk("n0_done", done_cnt, 1);
        chk("n0_done_lat", done_cyc - last_lp_cyc, 1);

        run(1, 16'd3, 1'b0, 1);
        chk("abort_pulses", lp_cnt, 1);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_stray", bad_lp, 0);
        chk("abort_idle", {62'd0, busy, act}, 64'd0);

        run(2, 16'd2, 1'b1, -1);
        chk("after_abort_pulses", lp_cnt, 4);
        chk("after_abort_infer", inf_cnt, 2);
        chk("after_abort_done", done_cnt, 1);
        chk("after_abort_lat", done_cyc - last_lp_cyc, 3);
        chk("after_abort_no_stray", bad_lp, 0);

        seed_in = 8'hA5; mode_log = 1'b1; n_infer = 16'd5;
        start = 1'b1; step(); start = 1'b0; step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_midop", {38'd0, obs}, 64'd0);

`ifdef PRIORS_SEQ_STOCH_COUNT_EN
        run(1, 16'd10, 1'b0, -1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stoch_row%0d", i), {48'd0, scnt[i*16 +: 16]}, (i % 2 == 0) ? 64'd10 : 64'd0);
        run(1, 16'd10, 1'b1, -1);
        chk("stoch_log_mode", scnt, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/priors_load_sequencer.md
Name: priors_load_sequencer

Overview:
Sequences one Bayesian run on the left-priors decoder of a single Narray tile.
- Programs the LFSR seed.
- Loads one prior word per row from a valid/ready stream.
- Holds inference for a programmed number of cycles, then reports done.
- Sits between the host/scan controller and the decoder control pins (activ_priors, load_priors, load_seed, adr_full_row, priors, seed, stoch_log, inference); the decoder is never driven directly by the host.

Parameters:
Narray, 2, log2 of row count; rows R = 2**Narray
Nword_used, 3, log2 of prior/seed width; W = 2**Nword_used
Ncnt, 16, width of inference-cycle counter and optional stochastic counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  return to IDLE and clear priors, any state
clear  in  1  in IDLE, drop activ_priors (flushes decoder stock)
mode_log  in  1  run mode, latched at start: 1 = log path, 0 = stochastic path
seed_in  in  W  LFSR seed, latched at start
n_infer  in  Ncnt  inference cycles, latched at start
prior_in  in  W  prior word stream, row order 0..R-1
prior_valid  in  1  prior_in valid
prior_ready  out  1  accept prior_in this cycle
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse on completion
activ_priors  out  1  decoder prior enable
load_priors  out  1  decoder prior write strobe
load_seed  out  1  decoder/LFSR seed strobe
adr_full_row  out  Narray  decoder row address
priors  out  W  decoder prior data
seed  out  W  decoder seed data
stoch_log  out  1  decoder mode
inference  out  1  decoder inference enable

Behaviour:
- All decoder-side outputs are registered. On rst, every output is 0, state = IDLE, all counters = 0.
- States: IDLE, SEED, LOAD, INFER, DONE.
- IDLE:
  - busy = 0, prior_ready = 0.
  - If start and not abort: latch mode_log, seed_in and n_infer, then go to SEED.
  - If clear: activ_priors <= 0.
  - start while busy is ignored.
- SEED (exactly 1 cycle):
  - Registered outputs: activ_priors = 1, load_seed = 1, seed = latched seed, stoch_log = latched mode, inference = 0.
  - Next state: LOAD with row = 0.
- LOAD:
  - prior_ready = 1 (combinational from state).
  - On prior_valid & prior_ready, register load_priors = 1, adr_full_row = row, priors = prior_in for the following cycle, then increment row.
  - Without a handshake, load_priors = 0 and adr_full_row/priors hold.
  - The handshake on row R-1 moves to INFER; row wraps to 0. Its load_priors pulse coincides with the first INFER cycle while inference is still 0.
  - inference is registered 1 cycle after entering INFER, so load never overlaps inference.
- INFER:
  - inference = 1 for exactly n_infer cycles, counted by a down counter.
  - n_infer = 0 skips INFER: LOAD goes directly to DONE and inference never asserts.
- DONE (1 cycle):
  - done = 1, inference = 0, then IDLE.
  - activ_priors stays 1 after DONE so the decoder keeps its priors until clear or the next start.
- abort, in any state:
  - Next cycle: IDLE; activ_priors, load_priors, load_seed, inference = 0; done not pulsed.
  - abort beats start and clear in the same cycle.
- rst mid-operation has the same effect as abort, plus all latched config is zeroed.
- stoch_log is constant from SEED to DONE.

Optional Feature:
PRIORS_SEQ_STOCH_COUNT_EN
- Enabled, adds ports:
  - priors_stoch_in, input, R bits.
  - stoch_count, output, R*Ncnt bits; row i occupies [i*Ncnt +: Ncnt].
- Behaviour when enabled:
  - Counters clear on entry to SEED.
  - Each INFER cycle with stoch_log = 0, counter i increments when priors_stoch_in[i] = 1, saturating at all-ones.
  - Values hold after DONE until the next start.
- Disabled: ports absent, no counter logic.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy = 0, prior_ready = 0.
- start, mode_log = 0, seed_in = 8'hA5, n_infer = 3; priors 8'h10, 8'h40, 8'h80, 8'hFF sent back-to-back -> load_seed 1 cycle with seed = A5; four load_priors pulses at adr 0,1,2,3 with matching data; inference high exactly 3 cycles; done 1 cycle; activ_priors stays 1.
- Same run with prior_valid gapped (valid every 3rd cycle) -> prior_ready held in LOAD; exactly 4 load_priors pulses; no pulse without a handshake.
- n_infer = 0 -> inference never asserts; done 1 cycle after the last load_priors.
- abort asserted on the 2nd prior of a run -> next cycle IDLE, activ_priors = 0, no done; a subsequent start runs normally from row 0.
- With PRIORS_SEQ_STOCH_COUNT_EN, n_infer = 10, priors_stoch_in = 4'b0101 held -> stoch_count rows 0,2 = 10, rows 1,3 = 0; mode_log = 1 gives all counts 0.
